// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and the logic that feeds it lock/soft
// requests and consumes the per-domain resets.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  logic                  lock;
  logic                  soft_rst_req;
  logic [NUM_STAGES-1:0] rst_out_n;
  logic                  ready;
  logic                  timeout;
  logic [1:0]            state;

  modport master (
    output lock,
    output soft_rst_req,
    input  rst_out_n,
    input  ready,
    input  timeout,
    input  state
  );

  modport slave (
    input  lock,
    input  soft_rst_req,
    output rst_out_n,
    output ready,
    output timeout,
    output state
  );
endinterface

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES downstream active-low resets in order, GAP_CYCLES apart, after a
// HOLD_CYCLES settle period and PLL lock; re-sequences on lock loss or soft request.
module reset_sequencer #(
  parameter int NUM_STAGES   = 3,
  parameter int HOLD_CYCLES  = 16,
  parameter int GAP_CYCLES   = 4,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  reset_sequencer_if.slave  bus
);

  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_CYC = (MAX_HG > LOCK_TIMEOUT) ? MAX_HG : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  // Synchronizers: reset deassertion and the asynchronous PLL lock.
  logic rst_meta_q, rst_s_q;
  logic lock_meta_q, lock_s_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta_q  <= 1'b0;
      rst_s_q     <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      rst_meta_q  <= 1'b1;
      rst_s_q     <= rst_meta_q;
      lock_meta_q <= bus.lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] out_q, out_d;
  logic                  ready_q, ready_d;
  logic                  timeout_q, timeout_d;
  logic [NUM_STAGES:0]   out_shift;
  logic                  abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      out_q     <= '0;
      ready_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      ready_q   <= ready_d;
      timeout_q <= timeout_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    ready_d   = ready_q;
    timeout_d = timeout_q;
    // Stages are a thermometer code: the next release shifts in one more 1 from bit 0.
    out_shift = {out_q, 1'b1};
    abort     = bus.soft_rst_req ||
                (!lock_s_q && (state_q == RELEASE || state_q == RUN));

    if (rst_s_q) begin
      if (abort) begin
        state_d = HOLD;
        cnt_d   = '0;
        out_d   = '0;
        ready_d = 1'b0;
      end else begin
        unique case (state_q)
          HOLD: begin
            if (cnt_q == HOLD_LAST) begin
              state_d = WAIT_LOCK;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          WAIT_LOCK: begin
            if (lock_s_q) begin
              state_d = RELEASE;
              cnt_d   = '0;
              out_d   = NUM_STAGES'(1);
            end else if (cnt_q == LOCK_LAST) begin
              // Lock never arrived: flag it and retry from a fresh hold period.
              state_d   = HOLD;
              cnt_d     = '0;
              timeout_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          RELEASE: begin
            if (cnt_q == GAP_LAST) begin
              cnt_d = '0;
              if (out_q[NUM_STAGES-1]) begin
                state_d = RUN;
                ready_d = 1'b1;
              end else begin
                out_d = out_shift[NUM_STAGES-1:0];
              end
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          RUN: begin
          end
          default: state_d = HOLD;
        endcase
      end
    end
  end

  assign bus.rst_out_n = out_q;
  assign bus.ready     = ready_q;
  assign bus.timeout   = timeout_q;
  assign bus.state     = state_q;

`ifndef SYNTHESIS
  a_ready_all_released: assert property (@(posedge clk) disable iff (!rst)
    ready_q |-> (&out_q));
  a_stage0_when_active: assert property (@(posedge clk) disable iff (!rst)
    (state_q == RELEASE || state_q == RUN) |-> out_q[0]);
  a_timeout_sticky: assert property (@(posedge clk) disable iff (!rst)
    timeout_q |=> timeout_q);
`endif

endmodule
